rtc_bus_arbiter: RTL and testbench
==================================

# rtc_bus_arbiter

Arbiter and sequencer that shares the single RTC bus-cycle engine between three transaction sources: power-up initialization, user register edits and the periodic time/date poll. Each requester presents one address/data/direction transaction and holds it until acknowledged. The arbiter picks a winner by fixed priority with anti-starvation aging, issues exactly one engine cycle, waits for completion or timeout, and returns read data or error. It sits between the RTC control state machines and the engine that drives CS/AD/RD/WR.

## Interface
Parameters:
- TIMEOUT_CYC, 255: max cycles in WAIT before abort; valid range 1..255.
- AGE_LIMIT, 4: consecutive lost arbitrations before a requester is promoted; valid range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req  in  3  request per source; bit 0 init, bit 1 user, bit 2 poll
- req_wr  in  3  per-source direction; 1 write, 0 read
- req_addr  in  24  packed {addr2, addr1, addr0}, 8 bits each
- req_wdata  in  24  packed {wdata2, wdata1, wdata0}
- ack  out  3  one-cycle completion pulse to the granted source
- err  out  3  one-cycle timeout pulse to the granted source, coincident with ack
- rdata  out  8  read result, valid while ack is high
- busy  out  1  high in every state except IDLE
- gnt_id  out  2  index of the current grant; 2'b11 when none
- eng_start  out  1  one-cycle pulse starting one engine bus cycle
- eng_wr  out  1  latched direction
- eng_addr  out  8  latched address
- eng_wdata  out  8  latched write data
- eng_done  in  1  one-cycle engine completion pulse
- eng_rdata  in  8  engine read data, valid with eng_done

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
- IDLE: if any req bit is high, select a winner, latch its wr/addr/wdata into eng_*, set gnt_id, go to ISSUE. Otherwise stay in IDLE.
- Winner selection: an aged source (age ≥ AGE_LIMIT) beats any non-aged source. Among aged sources, or when none is aged, the lowest index wins.
- Aging: each source has a 4-bit age counter. At every grant, each requesting loser increments its counter, saturating at 15. The winner's counter clears. Non-requesting sources clear their counters.
- ISSUE: eng_start=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - On eng_done, capture rdata = eng_wr ? 8'h00 : eng_rdata, then go to RESP.
  - If the counter reaches TIMEOUT_CYC without eng_done, set rdata=8'hFF, flag the error, go to RESP.
  - If eng_done and timeout occur on the same edge, eng_done wins and no error is flagged.
- RESP: ack[gnt_id]=1 (plus err[gnt_id] if flagged) for one cycle, then go to IDLE with gnt_id=2'b11.
- Requester rule: hold req and its fields stable until ack is seen. Deassert req on the edge that samples ack. If req is still high in the following IDLE cycle, it is treated as a new request.
- eng_done outside WAIT is ignored. req changes outside IDLE are ignored; latched fields do not change.
- Reset (any state, including mid-WAIT): return to IDLE. Outputs reset to ack=0, err=0, rdata=0, busy=0, gnt_id=2'b11, eng_start=0, eng_wr=0, eng_addr=0, eng_wdata=0. All age counters and the timeout counter clear. The engine shares the same reset, so no in-flight cycle survives.

## Timing
- req is sampled high at edge T. ISSUE and eng_start=1 occupy cycle T+1. WAIT begins at T+2.
- eng_done is sampled at edge D. RESP and ack occupy the cycle after D.
- With no contention, at least one IDLE cycle separates consecutive grants. Back-to-back minimum is 4 cycles plus engine latency.
- Timeout abort: ack/err are asserted in the cycle after the TIMEOUT_CYC-th WAIT cycle.

## Test plan
- Single read, source 2, addr 8'h21; engine returns 8'h45 three cycles after eng_start -> eng_start one cycle after req, eng_addr=8'h21, eng_wr=0; ack=3'b100 with rdata=8'h45 one cycle after eng_done.
- Simultaneous req=3'b111 -> grant order 0, 1, 2. Each ack is a single-cycle pulse, and gnt_id returns to 2'b11 between grants.
- Starvation, AGE_LIMIT=4: source 0 re-requests continuously and source 2 is held high -> source 2 is granted on its 5th arbitration, ahead of source 0, and its age then clears.
- Timeout, TIMEOUT_CYC=8, engine never responds -> ack and err both asserted on the granted bit, rdata=8'hFF, then return to IDLE. Repeat with eng_done on the 8th WAIT cycle -> ack only, no err.
- Reset asserted mid-WAIT of a write to 8'h0F -> next cycle all outputs at reset values. A stray eng_done afterward produces no ack.
- Write, source 1, addr 8'h02, wdata 8'h30 -> eng_wr=1, eng_wdata=8'h30 held through WAIT; ack=3'b010 with rdata=8'h00.

Source files
------------

// File: rtl/rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// rtc_bus_arbiter
// Shares the single RTC bus-cycle engine between three transaction sources
// (0: power-up init, 1: user edits, 2: periodic poll). A winner is chosen by
// fixed priority (lowest index) with aging so a persistently losing source is
// eventually promoted. Exactly one engine cycle is issued per grant. The
// arbiter then waits for completion or timeout and returns read data or an
// error pulse to the granted source.
//
// Ports
//   clk, reset             clock, synchronous active-high reset
//   req[2:0]               per-source request, held until ack
//   req_wr[2:0]            per-source direction (1 write, 0 read)
//   req_addr[23:0]         packed {addr2, addr1, addr0}
//   req_wdata[23:0]        packed {wdata2, wdata1, wdata0}
//   ack[2:0], err[2:0]     one-cycle completion / timeout pulses to the grantee
//   rdata[7:0]             read result, valid while ack is high
//   busy                   high whenever the sequencer is not idle
//   gnt_id[1:0]            current grant index, 2'b11 when none
//   eng_start              one-cycle engine start pulse
//   eng_wr/addr/wdata      latched transaction presented to the engine
//   eng_done, eng_rdata    engine completion pulse and read data
// -----------------------------------------------------------------------------
module rtc_bus_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int AGE_LIMIT   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [2:0]  req_wr,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    output logic [2:0]  ack,
    output logic [2:0]  err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [1:0]  gnt_id,
    output logic        eng_start,
    output logic        eng_wr,
    output logic [7:0]  eng_addr,
    output logic [7:0]  eng_wdata,
    input  logic        eng_done,
    input  logic [7:0]  eng_rdata
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYC);
    localparam logic [3:0] AGE_LIM   = 4'(AGE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    logic [2:0][3:0] age;
    logic [7:0]      tmo_cnt;
    logic [2:0]      aged;
    logic [1:0]      win;
    logic [4:0]      win_lsb;

    // Index of the lowest set bit, 2'd3 when the vector is empty.
    function automatic logic [1:0] lowest_set(input logic [2:0] v);
        logic [1:0] idx;
        if (v[0]) begin
            idx = 2'd0;
        end else if (v[1]) begin
            idx = 2'd1;
        end else if (v[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

    // Winner selection: any aged requester outranks all non-aged ones.
    always_comb begin
        aged = 3'b000;
        for (int i = 0; i < 3; i++) begin
            aged[i] = req[i] && (age[i] >= AGE_LIM);
        end
        if (aged != 3'b000) begin
            win = lowest_set(aged);
        end else begin
            win = lowest_set(req);
        end
        win_lsb = {win, 3'b000};
    end

    // Sequencer FSM with registered outputs, aging and timeout bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ack       <= 3'b000;
            err       <= 3'b000;
            rdata     <= 8'h00;
            busy      <= 1'b0;
            gnt_id    <= 2'b11;
            eng_start <= 1'b0;
            eng_wr    <= 1'b0;
            eng_addr  <= 8'h00;
            eng_wdata <= 8'h00;
            tmo_cnt   <= 8'h00;
            age       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 3'b000) begin
                        state     <= ISSUE;
                        busy      <= 1'b1;
                        gnt_id    <= win;
                        eng_start <= 1'b1;
                        eng_wr    <= req_wr[win];
                        eng_addr  <= req_addr[win_lsb +: 8];
                        eng_wdata <= req_wdata[win_lsb +: 8];
                        // Losers that are still asking get older; everyone
                        // else (winner and idle sources) starts over.
                        for (int i = 0; i < 3; i++) begin
                            if (2'(i) == win) begin
                                age[i] <= 4'h0;
                            end else if (req[i]) begin
                                age[i] <= (age[i] == 4'hF) ? 4'hF : age[i] + 4'd1;
                            end else begin
                                age[i] <= 4'h0;
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                ISSUE: begin
                    eng_start <= 1'b0;
                    tmo_cnt   <= 8'h00;
                    state     <= WAIT;
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    // Completion is checked first so it wins a tie with timeout.
                    if (eng_done) begin
                        rdata <= eng_wr ? 8'h00 : eng_rdata;
                        ack   <= 3'b001 << gnt_id;
                        state <= RESP;
                    end else if ((tmo_cnt + 8'd1) == TMO_LIMIT) begin
                        rdata <= 8'hFF;
                        ack   <= 3'b001 << gnt_id;
                        err   <= 3'b001 << gnt_id;
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    ack    <= 3'b000;
                    err    <= 3'b000;
                    busy   <= 1'b0;
                    gnt_id <= 2'b11;
                    state  <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    ack       <= 3'b000;
                    err       <= 3'b000;
                    busy      <= 1'b0;
                    gnt_id    <= 2'b11;
                    eng_start <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rtc_bus_arbiter
// Self-checking bench for rtc_bus_arbiter (TIMEOUT_CYC=8, AGE_LIMIT=4).
// Expected responses are queued when a request is driven and popped by a
// monitor whenever ack pulses. A behavioural engine answers eng_start after a
// programmable latency (0 = never answers).
// -----------------------------------------------------------------------------
module tb_rtc_bus_arbiter;

    logic        clk;
    logic        reset;
    logic [2:0]  req;
    logic [2:0]  req_wr;
    logic [23:0] req_addr;
    logic [23:0] req_wdata;
    logic [2:0]  ack;
    logic [2:0]  err;
    logic [7:0]  rdata;
    logic        busy;
    logic [1:0]  gnt_id;
    logic        eng_start;
    logic        eng_wr;
    logic [7:0]  eng_addr;
    logic [7:0]  eng_wdata;
    logic        eng_done;
    logic [7:0]  eng_rdata;

    rtc_bus_arbiter #(
        .TIMEOUT_CYC(8),
        .AGE_LIMIT  (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .ack      (ack),
        .err      (err),
        .rdata    (rdata),
        .busy     (busy),
        .gnt_id   (gnt_id),
        .eng_start(eng_start),
        .eng_wr   (eng_wr),
        .eng_addr (eng_addr),
        .eng_wdata(eng_wdata),
        .eng_done (eng_done),
        .eng_rdata(eng_rdata)
    );

    typedef struct packed {
        logic [2:0] a;
        logic [2:0] e;
        logic [7:0] d;
    } exp_t;

    exp_t       sb[$];
    int         tests = 0;
    int         fails = 0;
    int         resp_lat = 0;
    logic [7:0] resp_data = 8'h00;
    logic       stray_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: answers eng_start after resp_lat cycles, or a stray pulse.
    initial begin : engine
        int cd;
        cd        = 0;
        eng_done  = 1'b0;
        eng_rdata = 8'h00;
        forever begin
            @(negedge clk);
            #1;
            eng_done = 1'b0;
            if (reset) begin
                cd = 0;
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        eng_done  = 1'b1;
                        eng_rdata = resp_data;
                    end
                end
                if (eng_start && resp_lat > 0) cd = resp_lat;
            end
            if (stray_en) begin
                eng_done  = 1'b1;
                eng_rdata = 8'h99;
            end
        end
    end

    // Response monitor: every ack pulse is checked against the scoreboard.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && ack !== 3'b000) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_ack: ack=%b err=%b rdata=%h, none expected", ack, err, rdata);
                end else begin
                    e = sb.pop_front();
                    if (ack !== e.a || err !== e.e || rdata !== e.d) begin
                        fails++;
                        $display("FAIL response: got ack=%b err=%b rdata=%h, want ack=%b err=%b rdata=%h",
                                 ack, err, rdata, e.a, e.e, e.d);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input int s, input logic wr, input logic [7:0] a, input logic [7:0] d);
        req_wr[s]          = wr;
        req_addr[s*8 +: 8] = a;
        req_wdata[s*8 +: 8] = d;
        req[s]             = 1'b1;
    endtask

    task automatic wait_ack(input logic [2:0] m, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if ((ack & m) != 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 3'b000; req_wr = 3'b000; req_addr = 24'h0; req_wdata = 24'h0;
        repeat (2) @(negedge clk);
        tests++;
        if ({ack, err, rdata, busy, gnt_id, eng_start, eng_wr, eng_addr, eng_wdata} !==
            {3'b000, 3'b000, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            fails++;
            $display("FAIL reset_values: ack=%b err=%b rdata=%h busy=%b gnt=%b start=%b wr=%b addr=%h wdata=%h",
                     ack, err, rdata, busy, gnt_id, eng_start, eng_wr, eng_addr, eng_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        int n; bit ok;
        resp_lat = 3; resp_data = 8'h45;
        @(negedge clk);
        drive(2, 1'b0, 8'h21, 8'h00);
        sb.push_back('{a: 3'b100, e: 3'b000, d: 8'h45});
        @(negedge clk);
        tests++;
        if (eng_start !== 1'b1 || eng_addr !== 8'h21 || eng_wr !== 1'b0 || gnt_id !== 2'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL read_issue: start=%b addr=%h wr=%b gnt=%0d busy=%b, want 1 21 0 2 1",
                     eng_start, eng_addr, eng_wr, gnt_id, busy);
        end
        wait_ack(3'b100, n, ok);
        tests++;
        if (!ok || n !== 4) begin
            fails++;
            $display("FAIL read_latency: ack after %0d cycles (seen=%0d), want 4", n, ok);
        end
        req[2] = 1'b0;
        @(negedge clk);
        tests++;
        if (ack !== 3'b000 || gnt_id !== 2'b11 || busy !== 1'b0) begin
            fails++;
            $display("FAIL read_release: ack=%b gnt=%b busy=%b, want 000 11 0", ack, gnt_id, busy);
        end
    endtask

    task automatic test_write();
        int n; bit ok;
        resp_lat = 4; resp_data = 8'h77;
        @(negedge clk);
        drive(1, 1'b1, 8'h02, 8'h30);
        sb.push_back('{a: 3'b010, e: 3'b000, d: 8'h00});
        @(negedge clk);
        tests++;
        if (eng_start !== 1'b1 || eng_wr !== 1'b1 || eng_addr !== 8'h02 || eng_wdata !== 8'h30 || gnt_id !== 2'd1) begin
            fails++;
            $display("FAIL write_issue: start=%b wr=%b addr=%h wdata=%h gnt=%0d, want 1 1 02 30 1",
                     eng_start, eng_wr, eng_addr, eng_wdata, gnt_id);
        end
        // Fields wiggle after the grant; the latched copy must not follow.
        req_wdata[15:8] = 8'hFF; req_addr[15:8] = 8'hEE; req_wr[1] = 1'b0;
        n = 0; ok = 1'b0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (ack != 3'b000) begin
                ok = 1'b1;
                break;
            end
            tests++;
            if (eng_start !== 1'b0 || eng_wr !== 1'b1 || eng_wdata !== 8'h30 || eng_addr !== 8'h02 || busy !== 1'b1) begin
                fails++;
                $display("FAIL write_hold: start=%b wr=%b wdata=%h addr=%h busy=%b, want 0 1 30 02 1",
                         eng_start, eng_wr, eng_wdata, eng_addr, busy);
            end
        end
        tests++;
        if (!ok || n !== 5) begin
            fails++;
            $display("FAIL write_latency: ack after %0d cycles (seen=%0d), want 5", n, ok);
        end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority();
        int n; bit ok;
        resp_lat = 2; resp_data = 8'h3C;
        @(negedge clk);
        drive(0, 1'b0, 8'hA0, 8'h00);
        drive(1, 1'b0, 8'hA1, 8'h00);
        drive(2, 1'b0, 8'hA2, 8'h00);
        for (int k = 0; k < 3; k++) sb.push_back('{a: 3'(3'b001 << k), e: 3'b000, d: 8'h3C});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (eng_start !== 1'b1 || gnt_id !== 2'(k) || eng_addr !== (8'hA0 + 8'(k))) begin
                fails++;
                $display("FAIL prio_grant%0d: start=%b gnt=%0d addr=%h", k, eng_start, gnt_id, eng_addr);
            end
            wait_ack(3'b111, n, ok);
            tests++;
            if (!ok || ack !== 3'(3'b001 << k)) begin
                fails++;
                $display("FAIL prio_ack%0d: ack=%b seen=%0d, want %b", k, ack, ok, 3'(3'b001 << k));
            end
            req[k] = 1'b0;
            @(negedge clk);
            tests++;
            if (ack !== 3'b000 || gnt_id !== 2'b11) begin
                fails++;
                $display("FAIL prio_gap%0d: ack=%b gnt=%b, want 000 11", k, ack, gnt_id);
            end
        end
    endtask

    task automatic test_starvation();
        int n; bit ok;
        int want;
        resp_lat = 1; resp_data = 8'h11;
        @(negedge clk);
        drive(0, 1'b0, 8'hB0, 8'h00);
        drive(2, 1'b0, 8'hB2, 8'h00);
        for (int k = 0; k < 10; k++) begin
            want = (k == 4 || k == 9) ? 2 : 0;
            sb.push_back('{a: 3'(3'b001 << want), e: 3'b000, d: 8'h11});
        end
        for (int k = 0; k < 10; k++) begin
            want = (k == 4 || k == 9) ? 2 : 0;
            @(negedge clk);
            tests++;
            if (gnt_id !== 2'(want)) begin
                fails++;
                $display("FAIL starve_grant%0d: gnt=%0d, want %0d", k + 1, gnt_id, want);
            end
            wait_ack(3'b101, n, ok);
            tests++;
            if (!ok) begin
                fails++;
                $display("FAIL starve_ack%0d: no ack within %0d cycles", k + 1, n);
            end
            if (k == 9) req = 3'b000;
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        int n; bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            resp_lat  = (pass == 0) ? 0 : 8;
            resp_data = 8'h5A;
            @(negedge clk);
            drive(1, 1'b0, 8'h10, 8'h00);
            if (pass == 0) sb.push_back('{a: 3'b010, e: 3'b010, d: 8'hFF});
            else           sb.push_back('{a: 3'b010, e: 3'b000, d: 8'h5A});
            @(negedge clk);
            tests++;
            if (eng_start !== 1'b1 || gnt_id !== 2'd1) begin
                fails++;
                $display("FAIL tmo_issue%0d: start=%b gnt=%0d, want 1 1", pass, eng_start, gnt_id);
            end
            wait_ack(3'b010, n, ok);
            tests++;
            if (!ok || n !== 9) begin
                fails++;
                $display("FAIL tmo_latency%0d: ack after %0d cycles (seen=%0d), want 9", pass, n, ok);
            end
            req[1] = 1'b0;
            @(negedge clk);
            tests++;
            if (ack !== 3'b000 || err !== 3'b000 || busy !== 1'b0 || gnt_id !== 2'b11) begin
                fails++;
                $display("FAIL tmo_release%0d: ack=%b err=%b busy=%b gnt=%b", pass, ack, err, busy, gnt_id);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        resp_lat = 0;
        @(negedge clk);
        drive(0, 1'b1, 8'h0F, 8'hAA);
        @(negedge clk);
        tests++;
        if (eng_start !== 1'b1 || eng_wr !== 1'b1 || eng_addr !== 8'h0F || eng_wdata !== 8'hAA) begin
            fails++;
            $display("FAIL rst_issue: start=%b wr=%b addr=%h wdata=%h", eng_start, eng_wr, eng_addr, eng_wdata);
        end
        repeat (3) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_in_wait: busy=%b, want 1", busy);
        end
        reset = 1'b1;
        req   = 3'b000;
        @(negedge clk);
        tests++;
        if ({ack, err, rdata, busy, gnt_id, eng_start, eng_wr, eng_addr, eng_wdata} !==
            {3'b000, 3'b000, 8'h00, 1'b0, 2'b11, 1'b0, 1'b0, 8'h00, 8'h00}) begin
            fails++;
            $display("FAIL rst_mid_wait: ack=%b err=%b rdata=%h busy=%b gnt=%b start=%b wr=%b addr=%h wdata=%h",
                     ack, err, rdata, busy, gnt_id, eng_start, eng_wr, eng_addr, eng_wdata);
        end
        reset = 1'b0;
        @(negedge clk);
        stray_en = 1'b1;
        @(negedge clk);
        stray_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (ack !== 3'b000 || err !== 3'b000 || busy !== 1'b0) begin
                fails++;
                $display("FAIL stray_done%0d: ack=%b err=%b busy=%b, want 000 000 0", i, ack, err, busy);
            end
        end
    endtask

    initial begin : main
        test_reset();
        test_single_read();
        test_write();
        test_priority();
        test_starvation();
        test_timeout();
        test_reset_mid_wait();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
